// File: rtl/fp4_accumulator.sv
// rtl/fp4_accumulator.sv - sums LEN FP4 products into a signed fixed-point result (2 fractional bits).
// Optional build macro FP4_ACC_SATURATE_EN: clamp on overflow instead of wrapping.
module fp4_accumulator #(
  parameter int LEN   = 8,
  parameter int ACC_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data_valid,
  input  logic [3:0]       i_data,
  output logic             o_ready,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       count;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [4:0]       mag;
  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] dec;
  logic [ACC_W:0]   sum_ext;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_next;
  logic             accept;
  logic             last;
  logic             transfer;

  // Magnitude in quarter units: (2+man) << exp; the all-zero exp/man code is a true zero.
  always_comb begin
    mag = {3'b000, 1'b1, i_data[0]} << i_data[2:1];
    if (i_data[2:0] == 3'b000) begin
      mag = 5'd0;
    end
    mag_ext = {{(ACC_W-5){1'b0}}, mag};
    dec     = i_data[3] ? (~mag_ext + 1'b1) : mag_ext;
  end

  // One extra bit exposes the true signed result; a disagreement with the sign bit is overflow.
  always_comb begin
    sum_ext = {acc[ACC_W-1], acc} + {dec[ACC_W-1], dec};
    add_ovf = sum_ext[ACC_W] != sum_ext[ACC_W-1];
`ifdef FP4_ACC_SATURATE_EN
    if (add_ovf) begin
      acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_next = sum_ext[ACC_W-1:0];
    end
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
  end

  assign accept   = i_data_valid && o_ready;
  assign last     = accept && (count == 8'(LEN - 1));
  assign transfer = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      ACCUM: begin
        o_ready = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
    if (i_clear) begin
      state_next = ACCUM;
    end
  end

  // Clear and transfer both restart the vector; clear outranks any beat on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= 8'd0;
    end else if (i_clear || transfer) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= 8'd0;
    end else if (accept) begin
      acc   <= acc_next;
      ovf   <= ovf | add_ovf;
      count <= last ? 8'd0 : count + 8'd1;
    end
  end

  assign o_sum = acc;
  assign o_ovf = ovf;

endmodule

// File: tb/tb_fp4_accumulator.sv
// tb/tb_fp4_accumulator.sv - table-driven bench for fp4_accumulator at LEN=4 with ACC_W=16 and ACC_W=6.
module tb_fp4_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dv;
  logic [3:0]  data;
  logic        clr;
  logic        rdy;

  logic        r16, v16, o16;
  logic [15:0] s16;
  logic        r6, v6, o6;
  logic [5:0]  s6;

  int errs   = 0;
  int checks = 0;

  fp4_accumulator #(.LEN(4), .ACC_W(16)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(dv), .i_data(data), .o_ready(r16),
    .i_clear(clr), .o_valid(v16), .i_ready(rdy), .o_sum(s16), .o_ovf(o16)
  );

  fp4_accumulator #(.LEN(4), .ACC_W(6)) u6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(dv), .i_data(data), .o_ready(r6),
    .i_clear(clr), .o_valid(v6), .i_ready(rdy), .o_sum(s6), .o_ovf(o6)
  );

  typedef struct {
    logic [15:0] beats;   // beat 0 in [3:0]
    int          s16;
    int          s6_wrap;
    int          s6_sat;
    int          ovf6;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v, input bit chk6);
    logic [15:0] b;
    b = v.beats;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) chk({name, " valid_early"}, int'(v16), 0);
      dv   = 1'b1;
      data = b[4*k +: 4];
    end
    @(negedge clk);
    dv = 1'b0;
    chk({name, " valid"}, int'(v16), 1);
    chk({name, " ready_low"}, int'(r16), 0);
    chk({name, " sum16"}, int'($signed(s16)), v.s16);
    chk({name, " ovf16"}, int'(o16), 0);
    if (chk6) begin
`ifdef FP4_ACC_SATURATE_EN
      chk({name, " sum6"}, int'($signed(s6)), v.s6_sat);
`else
      chk({name, " sum6"}, int'($signed(s6)), v.s6_wrap);
`endif
      chk({name, " ovf6"}, int'(o6), v.ovf6);
    end
    @(negedge clk);
    chk({name, " valid_after"}, int'(v16), 0);
    chk({name, " ready_after"}, int'(r16), 1);
    chk({name, " sum_cleared"}, int'(s16), 0);
  endtask

  initial begin
    vecs[0] = '{16'h2222,  16,  16,  16, 0};
    vecs[1] = '{16'h03F7,   6,   6,   6, 0};
    vecs[2] = '{16'h0088,   0,   0,   0, 0};
    vecs[3] = '{16'h1191,   6,   6,   6, 0};
    vecs[4] = '{16'hFFFF, -96, -32, -32, 1};
    vecs[5] = '{16'h7654,  60,  -4,  31, 1};
    vecs[6] = '{16'hAEDC, -40,  24, -32, 1};
    vecs[7] = '{16'h7777,  96, -32,  31, 1};

    rst_n = 1'b0; dv = 1'b0; data = 4'h0; clr = 1'b0; rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst valid", int'(v16), 0);
    chk("rst ready", int'(r16), 1);
    chk("rst sum", int'(s16), 0);
    chk("rst ovf", int'(o16), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Backpressure: result held, beats ignored, next vector starts from zero.
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); dv = 1'b1; data = 4'h2;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data = 4'h7;
      chk("hold valid", int'(v16), 1);
      chk("hold ready", int'(r16), 0);
      chk("hold sum", int'(s16), 16);
    end
    @(negedge clk);
    chk("hold sum last", int'(s16), 16);
    dv = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk("hold released", int'(v16), 0);
    run_vec("after_hold", vecs[0], 1'b0);

    // Asynchronous reset mid-vector.
    @(negedge clk); dv = 1'b1; data = 4'h2;
    @(negedge clk); data = 4'h2;
    @(negedge clk); dv = 1'b0;
    chk("mid partial", int'(s16), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async sum", int'(s16), 0);
    chk("async valid", int'(v16), 0);
    chk("async ready", int'(r16), 1);
    @(negedge clk); rst_n = 1'b1;
    run_vec("after_rst", vecs[0], 1'b0);

    // Clear with a simultaneous beat: the beat is dropped.
    @(negedge clk); dv = 1'b1; data = 4'h2;
    @(negedge clk); data = 4'h2;
    @(negedge clk); clr = 1'b1; data = 4'h7;
    @(negedge clk); clr = 1'b0; dv = 1'b0;
    chk("clear sum", int'(s16), 0);
    run_vec("after_clr", '{16'h3333, 24, 24, 24, 0}, 1'b0);

    // Clear discards a pending result.
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); dv = 1'b1; data = 4'h7;
    end
    @(negedge clk); dv = 1'b0;
    chk("pend valid", int'(v16), 1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0; rdy = 1'b1;
    chk("pend dropped", int'(v16), 0);
    chk("pend sum", int'(s16), 0);
    chk("pend ovf6", int'(o6), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fp4_accumulator.md
FP4_ACCUMULATOR -- requirements
Module: fp4_accumulator

Interface
REQ-001 Parameter LEN, default 8: number of FP4 products summed per result (2..255).
REQ-002 Parameter ACC_W, default 16: signed fixed-point accumulator width, 2 fractional bits (6..32).
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_data_valid  in  1  i_data carries an FP4 product this cycle.
REQ-006 i_data  in  4  FP4 product {sign, exp[1:0], man}.
REQ-007 o_ready  out  1  block can accept i_data this cycle.
REQ-008 i_clear  in  1  synchronous flush of partial sum and counter.
REQ-009 o_valid  out  1  o_sum/o_ovf hold a completed result.
REQ-010 i_ready  in  1  downstream accepts result this cycle.
REQ-011 o_sum  out  ACC_W  signed sum in two's complement, LSB = 0.25.
REQ-012 o_ovf  out  1  at least one accumulate step in this result exceeded ACC_W range.

Function
REQ-013 Decode: magnitude*4 = (2+man) << exp; value negated when sign=1.
REQ-014 Codes 4'b0000 and 4'b1000 decode to exactly zero (reserved zero encoding).
REQ-015 Decode range: +/-3 .. +/-24 in LSB units; sign-extended to ACC_W before addition.
REQ-016 An input beat is accepted when i_data_valid && o_ready on a rising edge.
REQ-017 FSM states: ACCUM, DONE; reset state ACCUM.
REQ-018 ACCUM: o_ready=1, o_valid=0; each accepted beat adds decoded value to acc and increments count.
REQ-019 The accepted beat making count reach LEN moves FSM to DONE on the same edge, with acc holding the full sum; count returns to 0.
REQ-020 DONE: o_valid=1, o_ready=0; o_sum=acc, o_ovf=sticky flag; inputs ignored; values stable until transfer.
REQ-021 Transfer on o_valid && i_ready: next cycle ACCUM with acc=0, ovf=0, count=0; first new beat accepted that cycle.
REQ-022 Latency: o_valid asserts the cycle after the LEN-th accepted beat; throughput LEN beats per LEN+1 cycles with i_ready tied high.
REQ-023 i_clear (any state) on edge: acc=0, count=0, ovf=0, FSM=ACCUM; a result pending in DONE is discarded.
REQ-024 i_clear with simultaneous valid beat: clear wins, beat dropped.
REQ-025 Overflow detection: signed add of acc and decoded value whose true result lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1] sets sticky ovf.

Reset
REQ-026 i_rst_n low asynchronously forces: FSM=ACCUM, acc=0, count=0, ovf=0, o_valid=0, o_sum=0, o_ovf=0, o_ready=1 after release.
REQ-027 Reset mid-vector or in DONE discards all partial/pending state; no result emitted.
REQ-028 First beat accepted on the first rising edge with i_rst_n high.

Configuration
REQ-029 Macro FP4_ACC_SATURATE_EN defined: overflowing add clamps acc to max positive or min negative ACC_W value.
REQ-030 Macro FP4_ACC_SATURATE_EN undefined: overflowing add wraps modulo 2^ACC_W.
REQ-031 o_ovf reporting per REQ-025 is identical in both builds.

Verification
REQ-032 LEN=4, ACC_W=16, beats 0x2,0x2,0x2,0x2 back-to-back, i_ready=1 -> o_valid one cycle after 4th beat, o_sum=16 (4.0), o_ovf=0, o_ready low that cycle only.
REQ-033 LEN=4, beats 0x7,0xF,0x3,0x0 -> o_sum=6 (1.5); 0x0 contributes zero.
REQ-034 LEN=4, ACC_W=6, four 0x7 -> with FP4_ACC_SATURATE_EN o_sum=31, o_ovf=1; without it o_sum=-32 (6'b100000), o_ovf=1.
REQ-035 Result ready, i_ready=0 for 3 cycles while i_data_valid=1 with 0x7 -> o_sum/o_valid stable, o_ready=0, beats not summed; i_ready=1 -> next vector starts from 0.
REQ-036 Two beats accepted then i_rst_n pulsed low mid-cycle -> outputs zero immediately; next 4 beats of 0x2 yield o_sum=16.
REQ-037 Two beats accepted then i_clear=1 with valid 0x7 same cycle -> beat dropped; next 4 beats of 0x3 yield o_sum=24 (6.0).
